// File: rtl/rgb_to_gray_stream_if.sv
// Stream bundle for rgb_to_gray_stream: RGB beats in, gray beats out, frame statistics.
// Carries the thresh field only when GRAY_BINARIZE_EN is defined.
interface rgb_to_gray_stream_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 4
);
  logic [1:0]             mode;
  logic                   s_valid;
  logic                   s_ready;
  logic [LANES*PIX_W-1:0] s_r;
  logic [LANES*PIX_W-1:0] s_g;
  logic [LANES*PIX_W-1:0] s_b;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [LANES*PIX_W-1:0] m_gray;
  logic                   m_last;
  logic [15:0]            beat_cnt;
  logic                   frame_done;
`ifdef GRAY_BINARIZE_EN
  logic [PIX_W-1:0]       thresh;
`endif

  modport master (
`ifdef GRAY_BINARIZE_EN
    output thresh,
`endif
    output mode, s_valid, s_r, s_g, s_b, s_last, m_ready,
    input  s_ready, m_valid, m_gray, m_last, beat_cnt, frame_done
  );

  modport slave (
`ifdef GRAY_BINARIZE_EN
    input  thresh,
`endif
    input  mode, s_valid, s_r, s_g, s_b, s_last, m_ready,
    output s_ready, m_valid, m_gray, m_last, beat_cnt, frame_done
  );
endinterface

// File: rtl/rgb_to_gray_stream.sv
// Multi-lane RGB-to-gray converter, 3-stage pipeline with a global stall (valid/ready).
// Optional GRAY_BINARIZE_EN turns the S3 output into a thresholded 0 / full-scale value.
module rgb_to_gray_stream #(
  parameter int PIX_W = 8,
  parameter int LANES = 4
) (
  input logic              clk,
  input logic              rst_n,
  rgb_to_gray_stream_if.slave bus
);
  localparam int PROD_W = PIX_W + 9;
  localparam int SUM_W  = PIX_W + 11;
  localparam logic [PIX_W-1:0] GRAY_MAX = '1;

  logic       en;
  logic [8:0] w_r, w_g, w_b;
  logic       valid1_reg, valid2_reg, valid3_reg;
  logic       last1_reg, last2_reg, last3_reg;
  logic [8:0] wr1_reg, wg1_reg, wb1_reg;
  logic [15:0] cnt_reg;
  logic        frame_done_reg;
  logic        out_hs;
  logic [LANES*PIX_W-1:0] gray_flat;
`ifdef GRAY_BINARIZE_EN
  logic [PIX_W-1:0] thresh1_reg, thresh2_reg;
`endif

  // One enable for every stage: nothing moves while the output beat is stalled.
  assign en          = !valid3_reg || bus.m_ready;
  assign bus.s_ready = en;
  assign out_hs      = valid3_reg && bus.m_ready;

  always_comb begin
    w_r = 9'd77;
    w_g = 9'd150;
    w_b = 9'd29;
    case (bus.mode)
      2'd1:    begin w_r = 9'd85; w_g = 9'd86;  w_b = 9'd85; end
      2'd2:    begin w_r = 9'd0;  w_g = 9'd256; w_b = 9'd0;  end
      2'd3:    begin w_r = 9'd54; w_g = 9'd183; w_b = 9'd19; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_reg <= 1'b0;
      valid2_reg <= 1'b0;
      valid3_reg <= 1'b0;
      last1_reg  <= 1'b0;
      last2_reg  <= 1'b0;
      last3_reg  <= 1'b0;
      wr1_reg    <= '0;
      wg1_reg    <= '0;
      wb1_reg    <= '0;
`ifdef GRAY_BINARIZE_EN
      thresh1_reg <= '0;
      thresh2_reg <= '0;
`endif
    end else if (en) begin
      valid1_reg <= bus.s_valid;
      last1_reg  <= bus.s_last;
      wr1_reg    <= w_r;
      wg1_reg    <= w_g;
      wb1_reg    <= w_b;
      valid2_reg <= valid1_reg;
      last2_reg  <= last1_reg;
      valid3_reg <= valid2_reg;
      last3_reg  <= last2_reg;
`ifdef GRAY_BINARIZE_EN
      thresh1_reg <= bus.thresh;
      thresh2_reg <= thresh1_reg;
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [PIX_W-1:0]  r1_reg, g1_reg, b1_reg;
      logic [PROD_W-1:0] pr2_reg, pg2_reg, pb2_reg;
      logic [SUM_W-1:0]  sum, rounded;
      logic [PIX_W-1:0]  gray_sat, gray_next, gray3_reg;

      always_comb begin
        sum      = SUM_W'(pr2_reg) + SUM_W'(pg2_reg) + SUM_W'(pb2_reg);
        rounded  = (sum + SUM_W'(128)) >> 8;
        gray_sat = (rounded > SUM_W'(GRAY_MAX)) ? GRAY_MAX : rounded[PIX_W-1:0];
`ifdef GRAY_BINARIZE_EN
        gray_next = (gray_sat >= thresh2_reg) ? GRAY_MAX : '0;
`else
        gray_next = gray_sat;
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r1_reg    <= '0;
          g1_reg    <= '0;
          b1_reg    <= '0;
          pr2_reg   <= '0;
          pg2_reg   <= '0;
          pb2_reg   <= '0;
          gray3_reg <= '0;
        end else if (en) begin
          r1_reg    <= bus.s_r[gi*PIX_W +: PIX_W];
          g1_reg    <= bus.s_g[gi*PIX_W +: PIX_W];
          b1_reg    <= bus.s_b[gi*PIX_W +: PIX_W];
          pr2_reg   <= PROD_W'(wr1_reg) * PROD_W'(r1_reg);
          pg2_reg   <= PROD_W'(wg1_reg) * PROD_W'(g1_reg);
          pb2_reg   <= PROD_W'(wb1_reg) * PROD_W'(b1_reg);
          gray3_reg <= gray_next;
        end
      end

      assign gray_flat[gi*PIX_W +: PIX_W] = gray3_reg;
    end
  endgenerate

  // The visible count includes a beat being handed over this cycle, so the
  // last beat of an N-beat frame shows N before the counter clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= out_hs && last3_reg;
      if (out_hs) begin
        cnt_reg <= last3_reg ? 16'd0 : cnt_reg + 16'd1;
      end
    end
  end

  assign bus.m_valid    = valid3_reg;
  assign bus.m_last     = last3_reg;
  assign bus.m_gray     = gray_flat;
  assign bus.beat_cnt   = cnt_reg + {15'd0, out_hs};
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Self-checking bench for rgb_to_gray_stream: spec vectors, scoreboard against an arithmetic model.
// Define GRAY_BINARIZE_EN for both RTL and bench to exercise the threshold output.
module tb_rgb_to_gray_stream;
  localparam int PW   = 8;
  localparam int LN   = 4;
  localparam int GMAX = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rgb_to_gray_stream_if #(.PIX_W(PW), .LANES(LN)) bus ();

  rgb_to_gray_stream #(.PIX_W(PW), .LANES(LN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [LN*PW-1:0] gray;
    logic             last;
  } exp_t;

  typedef struct {
    int md;
    int r;
    int g;
    int b;
    int gray;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [LN*PW-1:0] obs[$];
  int   model_cnt;
  bit   prev_stall;
  logic [LN*PW-1:0] prev_gray;
  logic prev_last;
  bit   prev_last_hs;
  int   out_cnt = 0;
  int   fd_cnt = 0;
  int   last_hs_cnt = 0;
  int   th_val = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: weighted sum with round-half-up, clamped, optionally thresholded.
  function automatic int ref_gray(int md, int r, int g, int b);
    int wr, wg, wb, q;
    case (md)
      0:       begin wr = 77; wg = 150; wb = 29; end
      1:       begin wr = 85; wg = 86;  wb = 85; end
      2:       begin wr = 0;  wg = 256; wb = 0;  end
      default: begin wr = 54; wg = 183; wb = 19; end
    endcase
    q = (wr * r + wg * g + wb * b + 128) / 256;
    if (q > GMAX) q = GMAX;
`ifdef GRAY_BINARIZE_EN
    q = (q >= th_val) ? GMAX : 0;
`endif
    return q;
  endfunction

  function automatic logic [LN*PW-1:0] exp_vec();
    logic [LN*PW-1:0] v;
    for (int l = 0; l < LN; l++)
      v[l*PW +: PW] = PW'(ref_gray(int'(bus.mode), int'(bus.s_r[l*PW +: PW]),
                                   int'(bus.s_g[l*PW +: PW]), int'(bus.s_b[l*PW +: PW])));
    return v;
  endfunction

  task automatic monitor();
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      model_cnt    = 0;
      prev_stall   = 0;
      prev_last_hs = 0;
      return;
    end
    check("s_ready", 64'(bus.s_ready), 64'(!bus.m_valid || bus.m_ready));
    check("frame_done", 64'(bus.frame_done), 64'(prev_last_hs));
    if (bus.frame_done) fd_cnt++;
    if (prev_stall) begin
      check("hold_valid", 64'(bus.m_valid), 64'(1));
      check("hold_gray", 64'(bus.m_gray), 64'(prev_gray));
      check("hold_last", 64'(bus.m_last), 64'(prev_last));
    end
    prev_last_hs = 0;
    if (bus.m_valid && bus.m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_beat: got gray 0x%0h expected no beat at %0t", bus.m_gray, $time);
      end else begin
        e = sb.pop_front();
        check("out_gray", 64'(bus.m_gray), 64'(e.gray));
        check("out_last", 64'(bus.m_last), 64'(e.last));
        check("beat_cnt_hs", 64'(bus.beat_cnt), 64'((model_cnt + 1) % 65536));
        out_cnt++;
        obs.push_back(bus.m_gray);
        if (e.last) begin
          last_hs_cnt  = int'(bus.beat_cnt);
          model_cnt    = 0;
          prev_last_hs = 1;
        end else begin
          model_cnt = (model_cnt + 1) % 65536;
        end
      end
    end else begin
      check("beat_cnt_idle", 64'(bus.beat_cnt), 64'(model_cnt));
    end
    if (bus.s_valid && bus.s_ready) begin
      e.gray = exp_vec();
      e.last = bus.s_last;
      sb.push_back(e);
    end
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_gray  = bus.m_gray;
    prev_last  = bus.m_last;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int r, input int g, input int b);
    for (int l = 0; l < LN; l++) begin
      bus.s_r[l*PW +: PW] = PW'(r);
      bus.s_g[l*PW +: PW] = PW'(g);
      bus.s_b[l*PW +: PW] = PW'(b);
    end
  endtask

  task automatic set_rand();
    for (int l = 0; l < LN; l++) begin
      bus.s_r[l*PW +: PW] = PW'($urandom);
      bus.s_g[l*PW +: PW] = PW'($urandom);
      bus.s_b[l*PW +: PW] = PW'($urandom);
    end
  endtask

  task automatic drain(input int target);
    int n = 0;
    while (out_cnt < target && n < 60) begin
      tick();
      n++;
    end
    if (out_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats expected %0d", out_cnt, target);
    end
  endtask

  vec_t vt[6];

  initial begin
    int i, c, sr_low, out0, fd0, exp_g;
    bit hs;
    vt[0] = '{0, 255, 0,   0,   77};
    vt[1] = '{0, 255, 255, 255, 255};
    vt[2] = '{0, 0,   0,   0,   0};
    vt[3] = '{1, 30,  60,  90,  60};
    vt[4] = '{2, 10,  200, 50,  200};
    vt[5] = '{3, 128, 128, 128, 128};

    rst_n       = 1'b0;
    bus.mode    = 2'd0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    set_lanes(0, 0, 0);
`ifdef GRAY_BINARIZE_EN
    bus.thresh = PW'(th_val);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(bus.m_valid), 64'(0));
    check("rst_m_gray", 64'(bus.m_gray), 64'(0));
    check("rst_m_last", 64'(bus.m_last), 64'(0));
    check("rst_beat_cnt", 64'(bus.beat_cnt), 64'(0));
    check("rst_frame_done", 64'(bus.frame_done), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single-beat vectors: value and exact 3-cycle latency.
    for (int v = 0; v < 6; v++) begin
      bus.mode    = 2'(vt[v].md);
      set_lanes(vt[v].r, vt[v].g, vt[v].b);
      bus.s_valid = 1'b1;
      bus.s_last  = 1'b1;
      bus.m_ready = 1'b1;
      tick();
      bus.s_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        check($sformatf("latency_v%0d_c%0d", v, k), 64'(bus.m_valid), 64'(k == 3));
        if (k < 3) tick();
      end
      exp_g = vt[v].gray;
`ifdef GRAY_BINARIZE_EN
      exp_g = (exp_g >= th_val) ? GMAX : 0;
`endif
      check($sformatf("table_gray_v%0d", v), 64'(bus.m_gray), 64'({LN{PW'(exp_g)}}));
      tick();
    end

    // Mode changes every beat, back to back.
    for (int b = 0; b < 8; b++) begin
      bus.mode    = 2'(b % 4);
      set_rand();
      bus.s_valid = 1'b1;
      bus.s_last  = (b == 7);
      tick();
    end
    bus.s_valid = 1'b0;
    drain(out_cnt + sb.size());

    // 10-beat frame with a 5-cycle downstream stall.
    out0 = out_cnt; fd0 = fd_cnt; i = 0; c = 0; sr_low = 0;
    while ((out_cnt - out0) < 10 && c < 200) begin
      bus.m_ready = !(c >= 4 && c < 9);
      if (i < 10) begin
        bus.s_valid = 1'b1;
        bus.mode    = 2'($urandom_range(0, 3));
        set_rand();
        bus.s_last  = (i == 9);
      end else begin
        bus.s_valid = 1'b0;
      end
      #1;
      hs = bus.s_valid && bus.s_ready;
      if (bus.m_valid && !bus.s_ready) sr_low++;
      tick();
      if (hs) i++;
      c++;
    end
    check("stall_beats", 64'(out_cnt - out0), 64'(10));
    check("stall_frame_done", 64'(fd_cnt - fd0), 64'(1));
    check("stall_cnt_at_last", 64'(last_hs_cnt), 64'(10));
    check("stall_s_ready_low", 64'(sr_low > 0), 64'(1));
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick();

    // Random traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.m_ready = ($urandom_range(0, 2) != 0);
      bus.mode    = 2'($urandom_range(0, 3));
      bus.s_last  = ($urandom_range(0, 7) == 0);
      set_rand();
      tick();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    drain(out_cnt + sb.size());
    check("random_sb_empty", 64'(sb.size()), 64'(0));

    // Reset in the middle of a frame with beats in flight.
    bus.s_last = 1'b0;
    for (int n = 0; n < 9; n++) begin
      bus.m_ready = (n < 5);
      bus.s_valid = 1'b1;
      set_rand();
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 64'(bus.m_valid), 64'(0));
    check("midrst_beat_cnt", 64'(bus.beat_cnt), 64'(0));
    check("midrst_m_gray", 64'(bus.m_gray), 64'(0));
    tick();
    check("midrst_m_valid_next", 64'(bus.m_valid), 64'(0));
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    bus.mode    = 2'd0;
    set_lanes(200, 100, 50);
    bus.s_valid = 1'b1;
    bus.s_last  = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    drain(out_cnt + 1);
    check("post_rst_cnt", 64'(last_hs_cnt), 64'(1));

`ifdef GRAY_BINARIZE_EN
    // Threshold boundary: gray 99/100/101 against thresh 100.
    obs.delete();
    for (int b = 0; b < 3; b++) begin
      bus.mode    = 2'd0;
      set_lanes(99 + b, 99 + b, 99 + b);
      bus.s_valid = 1'b1;
      bus.s_last  = (b == 2);
      tick();
    end
    bus.s_valid = 1'b0;
    drain(out_cnt + sb.size());
    if (obs.size() == 3) begin
      check("bin_99", 64'(obs[0]), 64'({LN{8'd0}}));
      check("bin_100", 64'(obs[1]), 64'({LN{8'd255}}));
      check("bin_101", 64'(obs[2]), 64'({LN{8'd255}}));
    end else begin
      check("bin_count", 64'(obs.size()), 64'(3));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
